// File: rtl/argmax_classifier.sv
// argmax_classifier: sequential argmax over N_CLASSES signed scores, one comparison per cycle,
// reporting the winning index, its score and the margin over the runner-up.
module argmax_classifier #(
    parameter int DATA_W    = 16,
    parameter int N_CLASSES = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CLASSES*DATA_W-1:0] scores_in,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [3:0]                  digit,
    output logic [DATA_W-1:0]           max_score,
    output logic [DATA_W:0]             margin,
    output logic                        tie,
    output logic [7:0]                  frame_cnt
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam logic signed [DATA_W-1:0] MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [3:0] LAST = 4'(N_CLASSES - 1);
    state_t                   r_state;
    logic signed [DATA_W-1:0] r_sc [N_CLASSES];
    logic signed [DATA_W-1:0] r_best, r_second, r_max;
    logic [3:0]               r_idx, r_bidx, r_digit;
    logic [DATA_W:0]          r_margin;
    logic                     r_tie;
    logic [7:0]               r_fc;
    logic signed [DATA_W-1:0] w_s, w_best, w_second;
    logic [3:0]               w_bidx;
    logic [DATA_W:0]          w_margin;
    logic                     w_gt;
    always_comb begin
        w_s      = r_sc[r_idx];
        w_gt     = w_s > r_best;
        w_best   = w_gt ? w_s : r_best;
        w_bidx   = w_gt ? r_idx : r_bidx;
        w_second = w_gt ? r_best : (w_s > r_second ? w_s : r_second);
        // sign-extend both operands so the difference always fits
        w_margin = {w_best[DATA_W-1], w_best} - {w_second[DATA_W-1], w_second};
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_best   <= '0;
            r_second <= '0;
            r_bidx   <= '0;
            r_idx    <= '0;
            r_digit  <= '0;
            r_max    <= '0;
            r_margin <= '0;
            r_tie    <= 1'b0;
            r_fc     <= '0;
            for (int k = 0; k < N_CLASSES; k++) r_sc[k] <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    for (int k = 0; k < N_CLASSES; k++) r_sc[k] <= scores_in[k*DATA_W +: DATA_W];
                    r_best   <= scores_in[0 +: DATA_W];
                    r_bidx   <= '0;
                    r_second <= MIN;
                    r_idx    <= 4'd1;
                    r_state  <= SCAN;
                end
                SCAN: begin
                    r_best   <= w_best;
                    r_second <= w_second;
                    r_bidx   <= w_bidx;
                    r_idx    <= r_idx + 4'd1;
                    if (r_idx == LAST) begin
                        r_digit  <= w_bidx;
                        r_max    <= w_best;
                        r_margin <= w_margin;
                        r_tie    <= w_margin == '0;
                        r_state  <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    r_state <= IDLE;
                    r_fc    <= r_fc + 8'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign digit     = r_digit;
    assign max_score = r_max;
    assign margin    = r_margin;
    assign tie       = r_tie;
    assign frame_cnt = r_fc;
endmodule

// File: tb/tb_argmax_classifier.sv
// tb_argmax_classifier: directed vectors with hand-computed results for argmax_classifier.
module tb_argmax_classifier;
    localparam int W = 16, N = 10;
    logic           clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [N*W-1:0] scores_in = '0;
    logic           in_ready, out_valid, tie;
    logic [3:0]     digit;
    logic [W-1:0]   max_score;
    logic [W:0]     margin;
    logic [7:0]     frame_cnt, fc_last;
    int             errors = 0, checks = 0;
    int             v [N];
    int             pulses, last, cyc, bad;
    always #5 clk = ~clk;
    argmax_classifier #(.DATA_W(W), .N_CLASSES(N)) dut (
        .clk(clk), .reset(reset), .scores_in(scores_in), .in_valid(in_valid),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .digit(digit), .max_score(max_score), .margin(margin), .tie(tie),
        .frame_cnt(frame_cnt)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic set_scores(input int s [N]);
        for (int k = 0; k < N; k++) scores_in[k*W +: W] = 16'(s[k]);
    endtask
    task automatic run(input string tag);
        int n = 0;
        @(negedge clk) in_valid = 1'b1;
        @(posedge clk) #1 in_valid = 1'b0;
        while (!out_valid && n < 40) begin
            @(posedge clk) #1 n++;
        end
        check({tag, "_lat"}, n, 9);
    endtask
    initial begin
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_digit", digit, 0);
        check("rst_max", max_score, 0);
        check("rst_margin", margin, 0);
        check("rst_tie", tie, 0);
        check("rst_fc", frame_cnt, 0);
        @(negedge clk) reset = 1'b1;
        out_ready = 1'b1;
        v = '{5, 3, 100, 7, -2, 0, 99, 1, 1, 4};
        set_scores(v);
        run("t1");
        check("t1_digit", digit, 2);
        check("t1_max", max_score, 100);
        check("t1_margin", margin, 1);
        check("t1_tie", tie, 0);
        @(posedge clk) #1;
        check("t1_ready_after", in_ready, 1);
        check("t1_fc", frame_cnt, 1);
        v = '{-5, -1, -1, -8, -9, -9, -9, -9, -9, -9};
        set_scores(v);
        run("t2");
        check("t2_digit", digit, 1);
        check("t2_max", max_score, 16'hFFFF);
        check("t2_margin", margin, 0);
        check("t2_tie", tie, 1);
        @(posedge clk) #1;
        check("t2_fc", frame_cnt, 2);
        v = '{32767, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
        set_scores(v);
        run("t3");
        check("t3_digit", digit, 0);
        check("t3_max", max_score, 16'h7FFF);
        check("t3_margin", margin, 65535);
        check("t3_tie", tie, 0);
        @(posedge clk) #1;
        check("t3_fc", frame_cnt, 3);
        out_ready = 1'b0;
        v = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 5};
        set_scores(v);
        run("t4");
        check("t4_digit", digit, 8);
        check("t4_margin", margin, 10);
        @(negedge clk);
        v = '{99, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        set_scores(v);
        in_valid = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge clk) #1;
            if (digit !== 4'd8 || max_score !== 16'd90 || margin !== 17'd10 || tie !== 1'b0
                || in_ready !== 1'b0 || out_valid !== 1'b1 || frame_cnt !== 8'd3) bad++;
        end
        check("t4_stall_stable", bad, 0);
        @(negedge clk) begin out_ready = 1'b1; in_valid = 1'b0; end
        @(posedge clk) #1;
        check("t4_ready_next", in_ready, 1);
        check("t4_valid_drop", out_valid, 0);
        check("t4_fc", frame_cnt, 4);
        @(posedge clk) #1;
        check("t4_no_capture", in_ready, 1);
        check("t4_digit_held", digit, 8);
        v = '{5, 3, 100, 7, -2, 0, 99, 1, 1, 4};
        set_scores(v);
        @(negedge clk) in_valid = 1'b1;
        @(posedge clk) #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_ready", in_ready, 1);
        check("t5_rst_digit", digit, 0);
        check("t5_rst_max", max_score, 0);
        check("t5_rst_margin", margin, 0);
        check("t5_rst_fc", frame_cnt, 0);
        @(negedge clk) reset = 1'b1;
        bad = 0;
        repeat (15) begin
            @(posedge clk) #1;
            if (out_valid !== 1'b0) bad++;
        end
        check("t5_no_valid", bad, 0);
        v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 42};
        set_scores(v);
        run("t5");
        check("t5_digit", digit, 9);
        check("t5_max", max_score, 42);
        check("t5_margin", margin, 42);
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        v = '{5, 3, 100, 7, -2, 0, 99, 1, 1, 4};
        set_scores(v);
        pulses = 0; last = -1; cyc = 0; bad = 0; fc_last = '0;
        in_valid = 1'b1;
        while (pulses < 256 && cyc < 4000) begin
            @(posedge clk) #1 cyc++;
            if (out_valid) begin
                if (last >= 0 && cyc - last != 11) bad++;
                last = cyc;
                pulses++;
                fc_last = frame_cnt;
            end
        end
        @(negedge clk) in_valid = 1'b0;
        check("t6_pulses", pulses, 256);
        check("t6_period", bad, 0);
        check("t6_fc_255", fc_last, 255);
        check("t6_digit", digit, 2);
        @(posedge clk) #1;
        check("t6_fc_wrap", frame_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
